// File: rtl/ffnet_seq_pkg.sv
// ffnet_seq_pkg: shared FSM type, default parameters and counter-width helper
// for the feed-forward net sequencer.
package ffnet_seq_pkg;

  localparam int DEF_N_INPUTS       = 4;
  localparam int DEF_N_OUTPUTS      = 1;
  localparam int DEF_DECIM          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } seq_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ffnet_sequencer_onset_window.sv
// onset_window: serial onset-bit history window plus the decimation counter
// that raises an inference request every DECIM accepted samples.
// o_window is the post-shift view, so a request sees the sample that raised it.
module onset_window
  import ffnet_seq_pkg::*;
#(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int DECIM    = DEF_DECIM
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_sample_valid,
  input  logic                i_sample_bit,
  output logic [N_INPUTS-1:0] o_window,
  output logic                o_request
);

  localparam int            CW   = cnt_width(DECIM);
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [N_INPUTS-1:0] r_window;
  logic [N_INPUTS:0]   w_shifted;
  logic [N_INPUTS-1:0] w_window_next;
  logic [CW-1:0]       r_count;
  logic                w_wrap;

  assign w_shifted = {r_window, i_sample_bit};

  // Window value after this cycle's sample (newest bit lands in bit 0).
  always_comb begin
    if (i_sample_valid) begin
      w_window_next = w_shifted[N_INPUTS-1:0];
    end else begin
      w_window_next = r_window;
    end
  end

  // Request when the accepted sample completes a decimation period.
  always_comb begin
    if (i_sample_valid && (r_count == LAST)) begin
      w_wrap = 1'b1;
    end else begin
      w_wrap = 1'b0;
    end
  end

  // History shift register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_window <= {N_INPUTS{1'b0}};
    end else begin
      r_window <= w_window_next;
    end
  end

  // Decimation counter: counts accepted samples, wraps on a request.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= {CW{1'b0}};
    end else if (w_wrap) begin
      r_count <= {CW{1'b0}};
    end else if (i_sample_valid) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_window  = w_window_next;
  assign o_request = w_wrap;

endmodule

// File: rtl/ffnet_sequencer.sv
// ffnet_sequencer: owns net invocation timing. Triggers the LUT net from the
// onset window, waits for its result pulse and offers the prediction on a
// valid/ready handshake. Optional WAIT watchdog: define FFNET_SEQ_TIMEOUT_EN.
module ffnet_sequencer
  import ffnet_seq_pkg::*;
#(
  parameter int N_INPUTS       = DEF_N_INPUTS,
  parameter int N_OUTPUTS      = DEF_N_OUTPUTS,
  parameter int DECIM          = DEF_DECIM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic                 sample_bit,
  output logic                 net_trigger,
  output logic [N_INPUTS-1:0]  net_inputs,
  input  logic [N_OUTPUTS-1:0] net_outputs,
  input  logic                 net_ready,
  output logic                 pred_valid,
  output logic [N_OUTPUTS-1:0] pred_data,
  input  logic                 pred_ready,
  output logic                 overrun,
  output logic                 timeout
);

  logic [N_INPUTS-1:0]  w_window;
  logic                 w_request;
  seq_state_e           r_state;
  seq_state_e           w_state_next;
  logic                 r_pending;
  logic                 r_net_trigger;
  logic [N_INPUTS-1:0]  r_net_inputs;
  logic                 r_pred_valid;
  logic [N_OUTPUTS-1:0] r_pred_data;
  logic                 r_overrun;
  logic                 w_latch;
  logic                 w_capture;
  logic                 w_req_busy;
  logic                 w_drop;
  logic                 w_accept;
  logic                 w_overwrite;
  logic                 w_wait_expired;

  onset_window #(
    .N_INPUTS (N_INPUTS),
    .DECIM    (DECIM)
  ) u_window (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_sample_valid (sample_valid),
    .i_sample_bit   (sample_bit),
    .o_window       (w_window),
    .o_request      (w_request)
  );

`ifdef FFNET_SEQ_TIMEOUT_EN
  localparam int            TW     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout;

  // Counts WAIT cycles; restarts while in TRIG, i.e. on every entry to WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= {TW{1'b0}};
    end else if (r_state == TRIG) begin
      r_wait_cnt <= {TW{1'b0}};
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Watchdog fires on the last allowed WAIT cycle with no result.
  always_comb begin
    if ((r_state == WAIT) && !net_ready && (r_wait_cnt == T_LAST)) begin
      w_wait_expired = 1'b1;
    end else begin
      w_wait_expired = 1'b0;
    end
  end

  // Registered one-cycle timeout pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wait_expired;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_wait_expired       = 1'b0;
  assign timeout              = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_request || r_pending) w_state_next = TRIG;
        else                        w_state_next = IDLE;
      end
      TRIG: w_state_next = WAIT;
      WAIT: begin
        if (net_ready)           w_state_next = IDLE;
        else if (w_wait_expired) w_state_next = IDLE;
        else                     w_state_next = WAIT;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM output decode: latch/capture strobes and handshake/overrun events.
  always_comb begin
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request || r_pending) w_latch = 1'b1;
        else                        w_latch = 1'b0;
      end
      WAIT: begin
        if (net_ready) w_capture = 1'b1;
        else           w_capture = 1'b0;
      end
      default: begin
        w_latch   = 1'b0;
        w_capture = 1'b0;
      end
    endcase
    w_req_busy  = w_request && (r_state != IDLE);
    w_drop      = w_req_busy && r_pending;
    w_accept    = r_pred_valid && pred_ready;
    w_overwrite = w_capture && r_pred_valid && !w_accept;
  end

  // Pending flag: remembers one request that arrived while busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_latch) begin
      r_pending <= 1'b0;
    end else if (w_req_busy) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Registered outputs: trigger pulse, snapshot, prediction and overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_net_trigger <= 1'b0;
      r_net_inputs  <= {N_INPUTS{1'b0}};
      r_pred_valid  <= 1'b0;
      r_pred_data   <= {N_OUTPUTS{1'b0}};
      r_overrun     <= 1'b0;
    end else begin
      r_net_trigger <= (w_state_next == TRIG);
      if (w_latch) r_net_inputs <= w_window;
      else         r_net_inputs <= r_net_inputs;
      if (w_capture) begin
        r_pred_valid <= 1'b1;
        r_pred_data  <= net_outputs;
      end else if (w_accept) begin
        r_pred_valid <= 1'b0;
        r_pred_data  <= r_pred_data;
      end else begin
        r_pred_valid <= r_pred_valid;
        r_pred_data  <= r_pred_data;
      end
      r_overrun <= w_drop || w_overwrite;
    end
  end

  assign net_trigger = r_net_trigger;
  assign net_inputs  = r_net_inputs;
  assign pred_valid  = r_pred_valid;
  assign pred_data   = r_pred_data;
  assign overrun     = r_overrun;

endmodule

// File: doc/ffnet_sequencer.md
Name: ffnet_sequencer

Overview:
Initiator-side companion to the LUT feed-forward net core. It collects a serial beat-onset bit stream into an N_INPUTS-bit history window and fires the net's trigger every DECIM accepted samples. It then waits for the net's one-cycle result pulse, captures the prediction and presents it downstream on a valid/ready handshake. It sits between the onset detector and the beat-prediction consumer, and owns all timing of net invocations.

Parameters:
N_INPUTS, 4, history window width; equals net input bus width
N_OUTPUTS, 1, net output bus width
DECIM, 4, accepted samples between inference requests (>=1)
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with FFNET_SEQ_TIMEOUT_EN)

Ports:
clock  in  1  single system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
sample_valid  in  1  onset sample strobe
sample_bit  in  1  onset bit, valid when sample_valid=1
net_trigger  out  1  to net trigger; single-cycle pulse
net_inputs  out  N_INPUTS  to net input bus; window snapshot
net_outputs  in  N_OUTPUTS  from net output bus
net_ready  in  1  from net result-ready pulse
pred_valid  out  1  prediction available
pred_data  out  N_OUTPUTS  captured prediction
pred_ready  in  1  consumer accepts when pred_valid & pred_ready
overrun  out  1  one-cycle pulse: unconsumed prediction overwritten, or request dropped
timeout  out  1  one-cycle pulse on watchdog expiry (0 without macro)

Behaviour:
- Reset values: every output is 0. Window, decimation counter, pending flag and FSM are cleared; FSM state is IDLE. Reset asserted mid-inference aborts it. A later net_ready is ignored unless the FSM is in WAIT.
- Window: on sample_valid, window <= {window[N_INPUTS-2:0], sample_bit}. The newest bit is bit 0. Shifting continues in all FSM states.
- Decimation: the counter increments on each sample_valid. When it reaches DECIM-1 and a sample is accepted, the counter wraps to 0 and a request is raised in that same cycle. With DECIM=1, every sample raises a request.
- Request while FSM is not IDLE: sets the pending flag. A request while pending is already 1 is dropped and pulses overrun.
- The snapshot captures the window value after the current cycle's shift is applied.
- FSM:
  - IDLE: on a request or pending, latch net_inputs <= window (post-shift), clear pending, go to TRIG.
  - TRIG: net_trigger=1 for exactly this cycle, go to WAIT. net_ready is ignored in TRIG.
  - WAIT: on net_ready, pred_data <= net_outputs, pred_valid <= 1, go to IDLE.
- net_inputs stays stable from TRIG until the next latch.
- Trigger-to-capture latency depends on the net. Capture happens the cycle after net_ready is sampled high.
- Handshake:
  - pred_valid stays high until it is accepted.
  - On acceptance, pred_valid drops next cycle, unless a capture happens in the same cycle. In that case pred_valid stays 1 with the new data and there is no overrun.
  - A capture while pred_valid=1 and no acceptance overwrites pred_data and pulses overrun.
- Back-to-back: IDLE with pending set re-triggers on the cycle after capture. Minimum spacing between triggers is 3 cycles plus the net latency.

Optional Feature:
FFNET_SEQ_TIMEOUT_EN:
- Defined: a WAIT cycle counter is cleared on entry to WAIT. If it reaches TIMEOUT_CYCLES without net_ready, the FSM returns to IDLE, pulses timeout, and leaves pred_valid/pred_data unchanged.
- Undefined: WAIT holds indefinitely, the counter is not built, and timeout is tied to 0.

Decomposition:
- Package ffnet_seq_pkg: FSM state enum (IDLE, TRIG, WAIT), counter-width helper constant (clog2-based), default parameter values.
- Sub-module onset_window: window shift register plus decimation counter. Outputs are window and the request pulse.
- ffnet_sequencer contains the FSM, pending flag, output register/handshake and watchdog.

Test Plan:
1. Reset, then 4 samples 1,0,1,1 with DECIM=4 -> net_inputs=4'b1011 (bit0 newest), net_trigger high exactly 1 cycle. Net model answers net_ready after 5 cycles with 1 -> pred_valid=1, pred_data=1.
2. pred_ready held 0, two inferences complete -> second capture pulses overrun, pred_data holds the second result. Then pred_ready=1 for 1 cycle -> pred_valid=0 next cycle.
3. DECIM=1, sample every cycle, net latency 10 -> first extra request sets pending, a second extra request pulses overrun. Retrigger occurs 1 cycle after capture using the then-current window.
4. Acceptance and capture in the same cycle -> pred_valid stays 1, new data shown, overrun stays 0.
5. Reset asserted in WAIT, then a stray net_ready -> no capture, all outputs 0, next request triggers normally.
6. With FFNET_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, net never responds -> timeout pulses after 8 WAIT cycles, FSM returns to IDLE, pred_valid unchanged. Without the macro, the FSM is still in WAIT after 100 cycles and timeout stays 0.
